om_share_arbiter: RTL and testbench

- Shares one online-multiplier array instance (Stage digits, WL=2*Stage bits) between two requesters.
- Accepts operand pairs through a valid/grant handshake and arbitrates round-robin.
- Tracks each in-flight product with a requester tag through the multiplier's fixed latency.
- Returns each product into a per-requester result FIFO with valid/ack drain and credit-based backpressure.

---
 rtl/om_share_arbiter.sv | 151 +++++++++++++++
 tb/tb_om_share_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/om_share_arbiter.sv
// Round-robin share of one online multiplier between two requesters; products return LAT+1 cycles after grant.
// Backpressure: credits per requester cover in-flight tags plus result FIFO occupancy, so a full FIFO blocks its grants.

module om_share_fifo #(
  parameter int W     = 22,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         i_push,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop,
  output logic         o_vld,
  output logic [W-1:0] o_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_pop;

  // Pointer equality including the wrap bit means empty; credits keep the push side from overrunning.
  assign o_vld = (r_wr_ptr != r_rd_ptr);
  assign o_dat = r_mem[r_rd_ptr[AW-1:0]];
  assign w_pop = i_pop & o_vld;

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !Reset) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
  end
endmodule

module om_share_arbiter #(
  parameter int Stage  = 11,
  parameter int LAT    = 2,
  parameter int FDEPTH = 4
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 req0,
  input  logic [2*Stage-1:0]   x0,
  input  logic [2*Stage-3:0]   y0,
  output logic                 gnt0,
  input  logic                 req1,
  input  logic [2*Stage-1:0]   x1,
  input  logic [2*Stage-3:0]   y1,
  output logic                 gnt1,
  output logic [2*Stage-1:0]   om_x,
  output logic [2*Stage-3:0]   om_y,
  input  logic [2*Stage-1:0]   om_z,
  output logic                 res0_valid,
  output logic [2*Stage-1:0]   res0_z,
  input  logic                 res0_ack,
  output logic                 res1_valid,
  output logic [2*Stage-1:0]   res1_z,
  input  logic                 res1_ack,
  output logic                 busy
);
  localparam int WL = 2 * Stage;
  localparam int CW = $clog2(FDEPTH + 1);

  logic [CW-1:0]  r_cnt0;
  logic [CW-1:0]  r_cnt1;
  logic           r_last;
  logic [LAT-1:0] r_tag_vld;
  logic [LAT-1:0] r_tag_id;

  logic w_elig0, w_elig1;
  logic w_gnt0, w_gnt1;
  logic w_pop0, w_pop1;
  logic w_push0, w_push1;

  assign w_elig0 = req0 & (r_cnt0 < CW'(FDEPTH));
  assign w_elig1 = req1 & (r_cnt1 < CW'(FDEPTH));

  // r_last == 1 means requester 1 was granted most recently, so requester 0 wins a tie.
  assign w_gnt0 = !Reset & w_elig0 & (!w_elig1 | r_last);
  assign w_gnt1 = !Reset & w_elig1 & (!w_elig0 | !r_last);
  assign gnt0   = w_gnt0;
  assign gnt1   = w_gnt1;

  always_comb begin
    om_x = '0;
    om_y = '0;
    if (w_gnt0) begin
      om_x = x0;
      om_y = y0;
    end else if (w_gnt1) begin
      om_x = x1;
      om_y = y1;
    end
  end

  assign w_pop0  = res0_valid & res0_ack;
  assign w_pop1  = res1_valid & res1_ack;
  assign w_push0 = r_tag_vld[LAT-1] & !r_tag_id[LAT-1];
  assign w_push1 = r_tag_vld[LAT-1] &  r_tag_id[LAT-1];

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_cnt0    <= '0;
      r_cnt1    <= '0;
      r_last    <= 1'b1;
      r_tag_vld <= '0;
      r_tag_id  <= '0;
    end else begin
      r_cnt0 <= r_cnt0 + CW'(w_gnt0) - CW'(w_pop0);
      r_cnt1 <= r_cnt1 + CW'(w_gnt1) - CW'(w_pop1);
      if (w_gnt0) r_last <= 1'b0;
      if (w_gnt1) r_last <= 1'b1;
      r_tag_vld[0] <= w_gnt0 | w_gnt1;
      r_tag_id[0]  <= w_gnt1;
      for (int i = 1; i < LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_id[i]  <= r_tag_id[i-1];
      end
    end
  end

  om_share_fifo #(.W(WL), .DEPTH(FDEPTH)) u_fifo0 (
    .clk        (clk),
    .Reset      (Reset),
    .i_push     (w_push0),
    .i_push_dat (om_z),
    .i_pop      (res0_ack),
    .o_vld      (res0_valid),
    .o_dat      (res0_z)
  );

  om_share_fifo #(.W(WL), .DEPTH(FDEPTH)) u_fifo1 (
    .clk        (clk),
    .Reset      (Reset),
    .i_push     (w_push1),
    .i_push_dat (om_z),
    .i_pop      (res1_ack),
    .o_vld      (res1_valid),
    .o_dat      (res1_z)
  );

  assign busy = (|r_tag_vld) | res0_valid | res1_valid;
endmodule

// File: tb/tb_om_share_arbiter.sv
// Directed bench for om_share_arbiter; the multiplier is replaced by a LAT-cycle delay of om_x.
// Inputs change #1 after the rising edge, outputs are sampled on the falling edge.

module tb_om_share_arbiter;
  localparam int STAGE = 11;
  localparam int WL    = 2 * STAGE;

  logic          clk = 1'b0;
  logic          Reset;
  logic          req0, req1;
  logic [WL-1:0] x0, x1;
  logic [WL-3:0] y0, y1;
  logic          gnt0, gnt1;
  logic [WL-1:0] om_x;
  logic [WL-3:0] om_y;
  logic [WL-1:0] om_z;
  logic          res0_valid, res1_valid;
  logic [WL-1:0] res0_z, res1_z;
  logic          res0_ack, res1_ack;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  om_share_arbiter #(.Stage(STAGE), .LAT(2), .FDEPTH(4)) dut (
    .clk(clk), .Reset(Reset),
    .req0(req0), .x0(x0), .y0(y0), .gnt0(gnt0),
    .req1(req1), .x1(x1), .y1(y1), .gnt1(gnt1),
    .om_x(om_x), .om_y(om_y), .om_z(om_z),
    .res0_valid(res0_valid), .res0_z(res0_z), .res0_ack(res0_ack),
    .res1_valid(res1_valid), .res1_z(res1_z), .res1_ack(res1_ack),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Two-cycle multiplier stand-in: om_z(t+2) = om_x(t).
  logic [WL-1:0] m_d1, m_d2;
  always @(posedge clk) begin
    m_d1 <= om_x;
    m_d2 <= m_d1;
  end
  assign om_z = m_d2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          rst, r0;
    logic [WL-1:0] vx0;
    logic          r1;
    logic [WL-1:0] vx1;
    logic          a0, a1, full;
    logic          g0, g1;
    logic [WL-1:0] omx;
    logic          v0;
    logic [WL-1:0] z0;
    logic          v1;
    logic [WL-1:0] z1;
    logic          bsy;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic r0, input logic [WL-1:0] vx0,
                              input logic r1, input logic [WL-1:0] vx1,
                              input logic a0, input logic a1, input logic full,
                              input logic g0, input logic g1, input logic [WL-1:0] omx,
                              input logic v0, input logic [WL-1:0] z0,
                              input logic v1, input logic [WL-1:0] z1, input logic bsy);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.vx0 = vx0; v.r1 = r1; v.vx1 = vx1;
    v.a0 = a0; v.a1 = a1; v.full = full; v.g0 = g0; v.g1 = g1; v.omx = omx;
    v.v0 = v0; v.z0 = z0; v.v1 = v1; v.z1 = z1; v.bsy = bsy;
    return v;
  endfunction

  vec_t tbl[17];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          g;
    int            gcnt;
    int            nxt;
    logic [WL-1:0] got[$];
    logic          seen_v, seen_b, done;

    // reset / idle
    tbl[0]  = mk(1,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0);
    tbl[1]  = mk(1,0,0,0,0, 0,0,1, 0,0,0, 0,0,0,0,0);
    tbl[2]  = mk(1,0,0,0,0, 0,0,1, 0,0,0, 0,0,0,0,0);
    tbl[3]  = mk(0,0,0,0,0, 0,0,1, 0,0,0, 0,0,0,0,0);
    // round-robin with acks high
    tbl[4]  = mk(0,1,22'h0A0001,1,22'h0B0001, 1,1,1, 1,0,22'h0A0001, 0,0,0,0,0);
    tbl[5]  = mk(0,1,22'h0A0002,1,22'h0B0001, 1,1,1, 0,1,22'h0B0001, 0,0,0,0,1);
    tbl[6]  = mk(0,1,22'h0A0002,1,22'h0B0002, 1,1,1, 1,0,22'h0A0002, 0,0,0,0,1);
    tbl[7]  = mk(0,0,0,1,22'h0B0002,          1,1,1, 0,1,22'h0B0002, 1,22'h0A0001,0,0,1);
    tbl[8]  = mk(0,0,0,0,0, 1,1,1, 0,0,0, 0,0,1,22'h0B0001,1);
    tbl[9]  = mk(0,0,0,0,0, 1,1,1, 0,0,0, 1,22'h0A0002,0,0,1);
    tbl[10] = mk(0,0,0,0,0, 1,1,1, 0,0,0, 0,0,1,22'h0B0002,1);
    tbl[11] = mk(0,0,0,0,0, 1,1,1, 0,0,0, 0,0,0,0,0);
    // single transfer, popped on its first valid cycle
    tbl[12] = mk(0,1,22'h0ABCDE,0,0, 0,0,1, 1,0,22'h0ABCDE, 0,0,0,0,0);
    tbl[13] = mk(0,0,0,0,0, 0,0,1, 0,0,0, 0,0,0,0,1);
    tbl[14] = mk(0,0,0,0,0, 0,0,1, 0,0,0, 0,0,0,0,1);
    tbl[15] = mk(0,0,0,0,0, 1,0,1, 0,0,0, 1,22'h0ABCDE,0,0,1);
    tbl[16] = mk(0,0,0,0,0, 0,0,1, 0,0,0, 0,0,0,0,0);

    Reset = 1; req0 = 0; req1 = 0; x0 = '0; x1 = '0; y0 = '0; y1 = '0;
    res0_ack = 0; res1_ack = 0;
    next_cycle();

    for (int i = 0; i < 17; i++) begin
      Reset = tbl[i].rst; req0 = tbl[i].r0; x0 = tbl[i].vx0; req1 = tbl[i].r1; x1 = tbl[i].vx1;
      res0_ack = tbl[i].a0; res1_ack = tbl[i].a1;
      @(negedge clk);
      chk($sformatf("v%0d_gnt0", i), 32'(gnt0), 32'(tbl[i].g0));
      chk($sformatf("v%0d_gnt1", i), 32'(gnt1), 32'(tbl[i].g1));
      chk($sformatf("v%0d_om_x", i), 32'(om_x), 32'(tbl[i].omx));
      if (tbl[i].full) begin
        chk($sformatf("v%0d_res0_valid", i), 32'(res0_valid), 32'(tbl[i].v0));
        chk($sformatf("v%0d_res1_valid", i), 32'(res1_valid), 32'(tbl[i].v1));
        chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
        if (tbl[i].v0) chk($sformatf("v%0d_res0_z", i), 32'(res0_z), 32'(tbl[i].z0));
        if (tbl[i].v1) chk($sformatf("v%0d_res1_z", i), 32'(res1_z), 32'(tbl[i].z1));
      end
      next_cycle();
    end

    // Backpressure: FIFO0 never drained, requester 1 drained every cycle.
    req0 = 1; req1 = 1; res0_ack = 0; res1_ack = 1;
    x0 = 22'h000100; x1 = 22'h000200; gcnt = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      g = gnt0;
      if (g) gcnt++;
      if (c >= 8) begin
        chk($sformatf("bp_gnt1_c%0d", c), 32'(gnt1), 32'd1);
        chk($sformatf("bp_gnt0_c%0d", c), 32'(gnt0), 32'd0);
      end
      next_cycle();
      if (g) x0 = x0 + 1'b1;
      x1 = x1 + 1'b1;
    end
    chk("bp_gnt0_count", 32'(gcnt), 32'd4);
    chk("bp_res0_valid", 32'(res0_valid), 32'd1);
    chk("bp_res0_head", 32'(res0_z), 32'h100);
    res0_ack = 1;
    @(negedge clk);
    chk("bp_no_gnt_on_pop", 32'(gnt0), 32'd0);
    next_cycle();
    res0_ack = 0;
    @(negedge clk);
    chk("bp_regrant", 32'(gnt0), 32'd1);
    chk("bp_regrant_om_x", 32'(om_x), 32'h104);
    next_cycle();
    x0 = 22'h000105;
    @(negedge clk);
    chk("bp_hold_after_regrant", 32'(gnt0), 32'd0);
    next_cycle();
    req0 = 0; req1 = 0; res0_ack = 1;
    got.delete();
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (res0_valid) got.push_back(res0_z);
      if (!busy) done = 1;
      next_cycle();
    end
    chk("bp_drain", 32'(done), 32'd1);
    chk("bp_pop_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < got.size() && i < 4; i++)
      chk($sformatf("bp_pop%0d", i), 32'(got[i]), 32'h101 + 32'(i));

    // Order through a full FIFO1.
    res0_ack = 0; res1_ack = 0; req1 = 1; nxt = 1; x1 = 22'd1; gcnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      g = gnt1;
      if (g) gcnt++;
      next_cycle();
      if (g) begin
        nxt++;
        if (nxt > 6) req1 = 0; else x1 = WL'(nxt);
      end
    end
    @(negedge clk);
    chk("full_gnt_count", 32'(gcnt), 32'd4);
    chk("full_res1_valid", 32'(res1_valid), 32'd1);
    chk("full_res1_head", 32'(res1_z), 32'd1);
    next_cycle();
    res1_ack = 1;
    got.delete();
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      g = gnt1;
      if (res1_valid) got.push_back(res1_z);
      if (!busy && !req1) done = 1;
      next_cycle();
      if (g) begin
        nxt++;
        if (nxt > 6) req1 = 0; else x1 = WL'(nxt);
      end
    end
    chk("full_drain", 32'(done), 32'd1);
    chk("full_pop_count", 32'(got.size()), 32'd6);
    for (int i = 0; i < got.size() && i < 6; i++)
      chk($sformatf("full_pop%0d", i), 32'(got[i]), 32'(i + 1));

    // Reset while two products are in flight.
    res0_ack = 1; res1_ack = 1;
    req0 = 1; x0 = 22'h000011;
    @(negedge clk);
    chk("rst_pre_gnt0", 32'(gnt0), 32'd1);
    next_cycle();
    req0 = 0; req1 = 1; x1 = 22'h000022;
    @(negedge clk);
    chk("rst_pre_gnt1", 32'(gnt1), 32'd1);
    next_cycle();
    Reset = 1; req0 = 1; req1 = 1;
    @(negedge clk);
    chk("rst_cycle_gnt0", 32'(gnt0), 32'd0);
    chk("rst_cycle_gnt1", 32'(gnt1), 32'd0);
    chk("rst_cycle_om_x", 32'(om_x), 32'd0);
    next_cycle();
    Reset = 0; req0 = 0; req1 = 0;
    seen_v = 0; seen_b = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (res0_valid || res1_valid) seen_v = 1;
      if (busy) seen_b = 1;
      next_cycle();
    end
    chk("rst_no_result", 32'(seen_v), 32'd0);
    chk("rst_not_busy", 32'(seen_b), 32'd0);
    req0 = 1; req1 = 1; x0 = 22'h000033; x1 = 22'h000044; y0 = 20'h00ABC; y1 = 20'h00DEF;
    @(negedge clk);
    chk("rst_tie_gnt0", 32'(gnt0), 32'd1);
    chk("rst_tie_gnt1", 32'(gnt1), 32'd0);
    chk("rst_tie_om_x", 32'(om_x), 32'h33);
    chk("rst_tie_om_y", 32'(om_y), 32'hABC);
    next_cycle();
    req0 = 0; req1 = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
